bcd_stopwatch: RTL and testbench

//  Parametrised mm:ss.hh stopwatch for the DE1-SoC board: prescaler plus six cascaded BCD digit

---
 rtl/bcd_stopwatch.sv | 221 ++++++++++++++++++++++
 tb/tb_bcd_stopwatch.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch.sv
// mm:ss.hh stopwatch: prescaler, six cascaded BCD digits, run/stop/clear FSM, 7-seg decode.
// Latency: digits/flags update 1 cycle after the sampling edge; bcd/HEX are combinational from registers.
// No backpressure: pulse inputs are consumed every cycle. Optional lap hold under `LAP_HOLD_EN.
module bcd_stopwatch #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100,
    parameter int WRAP    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic        running,
    output logic        overflow,
    output logic        lap_active,
    output logic [23:0] bcd,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    // DIV must be at least 2 so the prescaler has a distinct terminal count.
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int PW      = $clog2(DIV);
    localparam bit WRAP_EN = (WRAP != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   presc_q;
    logic [PW-1:0]   presc_d;
    logic            running_q;
    logic            overflow_q;
    logic            overflow_d;

    // Live digits, least significant first: hundredths, seconds, minutes.
    logic [3:0] hu_q, ht_q, su_q, st_q, mu_q, mt_q;
    logic [3:0] hu_d, ht_d, su_d, st_d, mu_d, mt_d;
    logic [23:0] live;

    logic tick;
    logic c_ht, c_su, c_st, c_mu, c_mt;
    logic roll;
    logic locked;

    // Advance a digit, wrapping at its top value.
    function automatic logic [3:0] nxt(input logic [3:0] d, input logic [3:0] top);
        return (d == top) ? 4'd0 : d + 4'd1;
    endfunction

    // Active-low {g..a}; anything outside 0..9 blanks the digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign live = {mt_q, mu_q, st_q, su_q, ht_q, hu_q};
    assign tick = (state_q == S_RUN) && (presc_q == PW'(DIV - 1));

    // Carry chain: each stage advances only when every lower digit is at its top value.
    assign c_ht = tick && (hu_q == 4'd9);
    assign c_su = c_ht && (ht_q == 4'd9);
    assign c_st = c_su && (su_q == 4'd9);
    assign c_mu = c_st && (st_q == 4'd5);
    assign c_mt = c_mu && (mu_q == 4'd9);
    assign roll = c_mt && (mt_q == 4'd5);

    // In saturate mode a latched overflow freezes the watch until clear.
    assign locked = !WRAP_EN && overflow_q;

    // Next-state logic: clear wins over start_stop; saturation forces STOP.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_stop) state_d = S_RUN;
                end
                S_RUN: begin
                    if (start_stop || (!WRAP_EN && roll)) state_d = S_STOP;
                end
                S_STOP: begin
                    if (start_stop && !locked) state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Prescaler, digit cascade and overflow flag next values.
    always_comb begin
        presc_d    = presc_q;
        hu_d       = hu_q;
        ht_d       = ht_q;
        su_d       = su_q;
        st_d       = st_q;
        mu_d       = mu_q;
        mt_d       = mt_q;
        overflow_d = WRAP_EN ? 1'b0 : overflow_q;
        if (clear) begin
            presc_d    = '0;
            hu_d       = 4'd0;
            ht_d       = 4'd0;
            su_d       = 4'd0;
            st_d       = 4'd0;
            mu_d       = 4'd0;
            mt_d       = 4'd0;
            overflow_d = 1'b0;
        end else begin
            // Prescaler only moves in RUN, so STOP keeps the sub-tick phase.
            if (state_q == S_RUN) begin
                presc_d = tick ? '0 : presc_q + PW'(1);
            end
            if (roll) begin
                overflow_d = 1'b1;
            end
            // At 59:59.99 the saturating build simply holds the digits.
            if (tick && !(roll && !WRAP_EN)) begin
                hu_d = nxt(hu_q, 4'd9);
                if (c_ht) ht_d = nxt(ht_q, 4'd9);
                if (c_su) su_d = nxt(su_q, 4'd9);
                if (c_st) st_d = nxt(st_q, 4'd5);
                if (c_mu) mu_d = nxt(mu_q, 4'd9);
                if (c_mt) mt_d = nxt(mt_q, 4'd5);
            end
        end
    end

    // State, prescaler, digits and flags; reset outranks every other input.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            hu_q       <= 4'd0;
            ht_q       <= 4'd0;
            su_q       <= 4'd0;
            st_q       <= 4'd0;
            mu_q       <= 4'd0;
            mt_q       <= 4'd0;
            overflow_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            hu_q       <= hu_d;
            ht_q       <= ht_d;
            su_q       <= su_d;
            st_q       <= st_d;
            mu_q       <= mu_d;
            mt_q       <= mt_d;
            overflow_q <= overflow_d;
            running_q  <= (state_d == S_RUN);
        end
    end

    assign running  = running_q;
    assign overflow = overflow_q;

`ifdef LAP_HOLD_EN
    logic [23:0] lap_q;
    logic        lap_active_q;

    // Lap toggle: freeze on a RUN-time press (pre-tick value), release on any later press.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lap_q        <= 24'h0;
            lap_active_q <= 1'b0;
        end else if (clear) begin
            lap_active_q <= 1'b0;
        end else if (lap) begin
            if (lap_active_q) begin
                lap_active_q <= 1'b0;
            end else if (state_q == S_RUN) begin
                lap_active_q <= 1'b1;
                lap_q        <= live;
            end
        end
    end

    assign lap_active = lap_active_q;
    assign bcd        = lap_active_q ? lap_q : live;
`else
    logic lap_unused;

    assign lap_unused = lap;
    assign lap_active = 1'b0;
    assign bcd        = live;
`endif

    assign HEX0 = seg7(bcd[3:0]);
    assign HEX1 = seg7(bcd[7:4]);
    assign HEX2 = seg7(bcd[11:8]);
    assign HEX3 = seg7(bcd[15:12]);
    assign HEX4 = seg7(bcd[19:16]);
    assign HEX5 = seg7(bcd[23:20]);

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: wrap and saturate instances driven in parallel.
// Reference keeps elapsed time as an integer count of hundredths.
// Expected outputs queue per cycle; a monitor compares one cycle later.
module tb_bcd_stopwatch;

    localparam int DIV  = 10;
    localparam int MAXT = 359999;
    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_RUN  = 2'd1;
    localparam logic [1:0] M_STOP = 2'd2;
`ifdef LAP_HOLD_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    typedef struct packed {
        int         t;
        int         presc;
        logic [1:0] st;
        logic       ovf;
        logic       lap_on;
        int         lap_val;
        logic       wrap;
    } mdl_t;

    typedef struct packed {
        logic [23:0] w_bcd;
        logic        w_run;
        logic        w_ovf;
        logic        w_lap;
        logic [23:0] s_bcd;
        logic        s_run;
        logic        s_ovf;
        logic        s_lap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, ss, clr, lp;
    logic        w_running, w_overflow, w_lap_active;
    logic [23:0] w_bcd;
    logic [6:0]  hw0, hw1, hw2, hw3, hw4, hw5;
    logic        s_running, s_overflow, s_lap_active;
    logic [23:0] s_bcd;
    logic [6:0]  hs0, hs1, hs2, hs3, hs4, hs5;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    mdl_t mw, ms;
    logic [23:0] pre_d;

    always #5 clk = ~clk;

    bcd_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100), .WRAP(1)) dut_w (
        .clock(clk), .reset(rst_n), .start_stop(ss), .clear(clr), .lap(lp),
        .running(w_running), .overflow(w_overflow), .lap_active(w_lap_active), .bcd(w_bcd),
        .HEX0(hw0), .HEX1(hw1), .HEX2(hw2), .HEX3(hw3), .HEX4(hw4), .HEX5(hw5)
    );

    bcd_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100), .WRAP(0)) dut_s (
        .clock(clk), .reset(rst_n), .start_stop(ss), .clear(clr), .lap(lp),
        .running(s_running), .overflow(s_overflow), .lap_active(s_lap_active), .bcd(s_bcd),
        .HEX0(hs0), .HEX1(hs1), .HEX2(hs2), .HEX3(hs3), .HEX4(hs4), .HEX5(hs5)
    );

    function automatic logic [23:0] to_bcd(input int t);
        int mn, sc, hh;
        mn = t / 6000;
        sc = (t / 100) % 60;
        hh = t % 100;
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(hh / 10), 4'(hh % 10)};
    endfunction

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] hexes(input logic [23:0] b);
        return {seg(int'(b[23:20])), seg(int'(b[19:16])), seg(int'(b[15:12])),
                seg(int'(b[11:8])), seg(int'(b[7:4])), seg(int'(b[3:0]))};
    endfunction

    function automatic mdl_t mstep(input mdl_t mi, input bit r, input bit s, input bit c, input bit l);
        mdl_t m;
        bit tk;
        logic [1:0] ns;
        m = mi;
        if (!r) begin
            m.t = 0; m.presc = 0; m.st = M_IDLE; m.ovf = 1'b0; m.lap_on = 1'b0; m.lap_val = 0;
            return m;
        end
        if (c) begin
            m.t = 0; m.presc = 0; m.st = M_IDLE; m.ovf = 1'b0; m.lap_on = 1'b0;
            return m;
        end
        tk = (m.st == M_RUN) && (m.presc == DIV - 1);
        if (LAP_EN && l) begin
            if (m.lap_on) m.lap_on = 1'b0;
            else if (m.st == M_RUN) begin
                m.lap_on  = 1'b1;
                m.lap_val = m.t;
            end
        end
        ns = m.st;
        if (s) begin
            if (m.st == M_IDLE) ns = M_RUN;
            else if (m.st == M_RUN) ns = M_STOP;
            else if (!(m.wrap == 1'b0 && m.ovf)) ns = M_RUN;
        end
        if (m.wrap) m.ovf = 1'b0;
        if (m.st == M_RUN) m.presc = tk ? 0 : m.presc + 1;
        if (tk) begin
            if (m.t == MAXT) begin
                m.ovf = 1'b1;
                if (m.wrap) m.t = 0;
                else ns = M_STOP;
            end else begin
                m.t = m.t + 1;
            end
        end
        m.st = ns;
        return m;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // One driven cycle: apply inputs, advance both references, queue what the DUTs must show.
    task automatic cyc(input bit r, input bit s, input bit c, input bit l);
        exp_t e;
        rst_n = r; ss = s; clr = c; lp = l;
        mw = mstep(mw, r, s, c, l);
        ms = mstep(ms, r, s, c, l);
        e.w_bcd = to_bcd(mw.lap_on ? mw.lap_val : mw.t);
        e.w_run = (mw.st == M_RUN);
        e.w_ovf = mw.ovf;
        e.w_lap = mw.lap_on;
        e.s_bcd = to_bcd(ms.lap_on ? ms.lap_val : ms.t);
        e.s_run = (ms.st == M_RUN);
        e.s_ovf = ms.ovf;
        e.s_lap = ms.lap_on;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Jump the time of both (non-running) instances; the digits then count on from there.
    task preload(input int t);
        pre_d = to_bcd(t);
        force dut_w.hu_q = pre_d[3:0];   force dut_s.hu_q = pre_d[3:0];
        force dut_w.ht_q = pre_d[7:4];   force dut_s.ht_q = pre_d[7:4];
        force dut_w.su_q = pre_d[11:8];  force dut_s.su_q = pre_d[11:8];
        force dut_w.st_q = pre_d[15:12]; force dut_s.st_q = pre_d[15:12];
        force dut_w.mu_q = pre_d[19:16]; force dut_s.mu_q = pre_d[19:16];
        force dut_w.mt_q = pre_d[23:20]; force dut_s.mt_q = pre_d[23:20];
        #1;
        release dut_w.hu_q; release dut_s.hu_q;
        release dut_w.ht_q; release dut_s.ht_q;
        release dut_w.su_q; release dut_s.su_q;
        release dut_w.st_q; release dut_s.st_q;
        release dut_w.mu_q; release dut_s.mu_q;
        release dut_w.mt_q; release dut_s.mt_q;
        mw.t = t;
        ms.t = t;
    endtask

    // Monitor: after each edge, pop the expectation queued for it and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("w_bcd", 64'(w_bcd), 64'(e.w_bcd));
                check("w_running", 64'(w_running), 64'(e.w_run));
                check("w_overflow", 64'(w_overflow), 64'(e.w_ovf));
                check("w_lap_active", 64'(w_lap_active), 64'(e.w_lap));
                check("w_hex", 64'({hw5, hw4, hw3, hw2, hw1, hw0}), 64'(hexes(e.w_bcd)));
                check("s_bcd", 64'(s_bcd), 64'(e.s_bcd));
                check("s_running", 64'(s_running), 64'(e.s_run));
                check("s_overflow", 64'(s_overflow), 64'(e.s_ovf));
                check("s_lap_active", 64'(s_lap_active), 64'(e.s_lap));
                check("s_hex", 64'({hs5, hs4, hs3, hs2, hs1, hs0}), 64'(hexes(e.s_bcd)));
            end
        end
    end

    initial begin
        #(150000 * 10);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        mw = '0; ms = '0;
        mw.wrap = 1'b1;
        ms.wrap = 1'b0;
        rst_n = 1'b0; ss = 1'b0; clr = 1'b0; lp = 1'b0;
        @(negedge clk);

        // Reset with pulses asserted: reset must dominate.
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b1, 0);
        idle(1);
        check("reset_bcd", 64'(w_bcd), 64'h0);
        check("reset_hex0", 64'(hw0), 64'(7'b1000000));
        check("reset_hex5", 64'(hs5), 64'(7'b1000000));
        check("reset_running", 64'(w_running), 64'h0);
        check("reset_overflow", 64'(s_overflow), 64'h0);

        // 123 hundredths of running, then stop and hold.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1230);
        check("run_123_bcd", 64'(w_bcd), 64'h000123);
        check("run_123_running", 64'(w_running), 64'h1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(500);
        check("stop_hold_bcd", 64'(w_bcd), 64'h000123);
        check("stop_running", 64'(w_running), 64'h0);

        // Rollover from 59:59.90 on both instances.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        preload(359990);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(99);
        check("max_w_bcd", 64'(w_bcd), 64'h595999);
        check("max_s_bcd", 64'(s_bcd), 64'h595999);
        check("max_w_ovf", 64'(w_overflow), 64'h0);
        idle(1);
        check("wrap_bcd", 64'(w_bcd), 64'h0);
        check("wrap_ovf", 64'(w_overflow), 64'h1);
        check("wrap_running", 64'(w_running), 64'h1);
        check("sat_bcd", 64'(s_bcd), 64'h595999);
        check("sat_ovf", 64'(s_overflow), 64'h1);
        check("sat_running", 64'(s_running), 64'h0);
        idle(1);
        check("wrap_ovf_pulse_end", 64'(w_overflow), 64'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("sat_ss_ignored_run", 64'(s_running), 64'h0);
        check("sat_ss_ignored_bcd", 64'(s_bcd), 64'h595999);
        check("sat_ovf_sticky", 64'(s_overflow), 64'h1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("sat_clear_bcd", 64'(s_bcd), 64'h0);
        check("sat_clear_ovf", 64'(s_overflow), 64'h0);

        // clear beats start_stop; stop/restart keeps prescaler phase.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(17);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_ss_bcd", 64'(w_bcd), 64'h0);
        check("clr_ss_running", 64'(w_running), 64'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(16);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(5);
        check("phase_stop_bcd", 64'(w_bcd), 64'h000001);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("phase_before_tick", 64'(w_bcd), 64'h000001);
        idle(1);
        check("phase_tick_3", 64'(w_bcd), 64'h000002);

        // Lap freeze and release.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2000);
        check("lap_pre_bcd", 64'(w_bcd), 64'h000200);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        idle(1000);
`ifdef LAP_HOLD_EN
        check("lap_active", 64'(w_lap_active), 64'h1);
        check("lap_frozen_bcd", 64'(w_bcd), 64'h000200);
`else
        check("lap_ignored_active", 64'(w_lap_active), 64'h0);
        check("lap_ignored_bcd", 64'(w_bcd), 64'h000300);
`endif
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("lap_release_bcd", 64'(w_bcd), 64'h000300);
        check("lap_release_active", 64'(w_lap_active), 64'h0);

        // Randomised pulses starting close to the rollover point.
        for (int blk = 0; blk < 4; blk++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0);
            preload(359900 + int'($urandom_range(0, 99)));
            for (int i = 0; i < 1200; i++) begin
                cyc($urandom_range(0, 599) != 0, $urandom_range(0, 149) == 0,
                    $urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0);
            end
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
